// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 (x^16+x^15+x^2+1) frame checker with trailer strip.
// Define CRC_STATS_EN to build the good/bad frame counters.
module crc16_frame_checker #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             frame_end,
  output logic             payload_bit,
  output logic             payload_valid,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic [15:0]      good_count,
  output logic [15:0]      bad_count
);
  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'((1 << LEN_W) + 15);
  localparam logic [CNT_W-1:0] CNT_16 = CNT_W'(16);
  localparam logic [CNT_W-1:0] CNT_17 = CNT_W'(17);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_REPORT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_lfsr;
  logic [15:0]      r_dly;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_pay_bit;
  logic             r_pay_valid;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len;
  logic             w_load;
  logic             w_step;
  logic             w_emit;
  logic             w_ok;

  function automatic logic [15:0] f_step(
    input logic [15:0] r,
    input logic        d
  );
    logic fb;
    fb = r[15] ^ d;
    return {r[14] ^ fb, r[13:2], r[1] ^ fb, r[0], fb};
  endfunction

  // A start bit restarts the frame from any state.
  assign w_load = bit_valid & frame_start;
  assign w_step = bit_valid & ~frame_start
                & (r_state == S_RUN);
  assign w_emit = w_step & (r_cnt >= CNT_16);
  assign w_ok   = (r_lfsr == 16'h0000)
                & (r_cnt >= CNT_17) & ~r_ovf;
  assign w_len  = (r_cnt < CNT_16) ? '0
                : LEN_W'(r_cnt - CNT_16);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN: begin
        if (bit_valid & frame_end)
          w_next = S_REPORT;
      end
      S_IDLE, S_REPORT: begin
        if (w_load)
          w_next = frame_end ? S_REPORT : S_RUN;
        else
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 16'hFFFF;
      r_dly  <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else if (w_load) begin
      r_lfsr <= f_step(16'hFFFF, bit_in);
      r_dly  <= {r_dly[14:0], bit_in};
      r_cnt  <= CNT_W'(1);
      r_ovf  <= 1'b0;
    end else if (w_step) begin
      r_lfsr <= f_step(r_lfsr, bit_in);
      r_dly  <= {r_dly[14:0], bit_in};
      if (r_cnt == CNT_MAX) r_ovf <= 1'b1;
      else                  r_cnt <= r_cnt + 1'b1;
    end
  end

  // The delay line holds back the last 16 bits, the trailer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pay_bit   <= 1'b0;
      r_pay_valid <= 1'b0;
    end else begin
      r_pay_valid <= w_emit;
      r_pay_bit   <= w_emit & r_dly[15];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                    r_len <= '0;
    else if (r_state == S_REPORT) r_len <= w_len;
  end

  always_comb begin
    payload_bit   = r_pay_bit;
    payload_valid = r_pay_valid;
    done          = 1'b0;
    crc_ok        = 1'b0;
    crc_err       = 1'b0;
    busy          = 1'b0;
    frame_len     = r_len;
    unique case (r_state)
      S_RUN: busy = 1'b1;
      S_REPORT: begin
        done      = 1'b1;
        crc_ok    = w_ok;
        crc_err   = ~w_ok;
        frame_len = w_len;
      end
      default: ;
    endcase
  end

`ifdef CRC_STATS_EN
  logic [15:0] r_good;
  logic [15:0] r_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_good <= '0;
      r_bad  <= '0;
    end else if (r_state == S_REPORT) begin
      if (w_ok && r_good != 16'hFFFF)
        r_good <= r_good + 1'b1;
      if (!w_ok && r_bad != 16'hFFFF)
        r_bad <= r_bad + 1'b1;
    end
  end

  assign good_count = r_good;
  assign bad_count  = r_bad;
`else
  assign good_count = '0;
  assign bad_count  = '0;
`endif

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Bench for crc16_frame_checker: directed and random frames
// checked against a frame-level CRC model.
module tb_crc16_frame_checker;
  localparam int LEN_W = 12;
  localparam int MAXP  = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             frame_start = 1'b0;
  logic             frame_end = 1'b0;
  logic             payload_bit;
  logic             payload_valid;
  logic             done;
  logic             crc_ok;
  logic             crc_err;
  logic [LEN_W-1:0] frame_len;
  logic             busy;
  logic [15:0]      good_count;
  logic [15:0]      bad_count;

  crc16_frame_checker #(.LEN_W(LEN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .payload_bit  (payload_bit),
    .payload_valid(payload_valid),
    .done         (done),
    .crc_ok       (crc_ok),
    .crc_err      (crc_err),
    .frame_len    (frame_len),
    .busy         (busy),
    .good_count   (good_count),
    .bad_count    (bad_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    bit ok;
    bit err;
    int len;
  } drec_t;

  drec_t obs_done[$];
  drec_t exp_done[$];
  bit    obs_pay[$];
  bit    exp_pay[$];
  int    stray = 0;
  int    checks = 0;
  int    errors = 0;
  int    exp_good = 0;
  int    exp_bad = 0;
  int    last_len = 0;

  always @(negedge clk) begin
    if (payload_valid === 1'b1) obs_pay.push_back(payload_bit);
    if (done === 1'b1)
      obs_done.push_back(drec_t'{cyc, crc_ok, crc_err,
                                 int'(frame_len)});
    else if ((crc_ok | crc_err) !== 1'b0)
      stray++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_of(input bit q[$]);
    logic [15:0] c;
    bit          top;
    c = 16'hFFFF;
    foreach (q[i]) begin
      top = c[15] ^ q[i];
      c   = c << 1;
      if (top) c = c ^ 16'h8005;
    end
    return c;
  endfunction

  task automatic step(input bit v, input bit b,
                      input bit fs, input bit fe);
    bit_valid   = v;
    bit_in      = b;
    frame_start = fs;
    frame_end   = fe;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Frame-level model: the last 16 bits are the trailer, the rest payload.
  task automatic send_raw(input bit q[$], input bit with_end,
                          input int gap_pct);
    int          n;
    int          pl;
    bit          ok;
    logic [15:0] tr;
    bit          pay[$];
    n = q.size();
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0)
        while ($urandom_range(99) < gap_pct) idle(1);
      step(1'b1, q[i], i == 0, with_end && (i == n - 1));
    end
    pl = n - 16;
    for (int i = 0; i < pl; i++) exp_pay.push_back(q[i]);
    if (with_end) begin
      ok = 1'b0;
      if (pl >= 1 && pl <= MAXP) begin
        tr = '0;
        for (int i = pl; i < n; i++) tr = {tr[14:0], q[i]};
        pay = q[0:pl-1];
        ok = (crc_of(pay) == tr);
      end
      exp_done.push_back(drec_t'{cyc, ok, !ok,
        (pl < 0) ? 0 : ((pl > MAXP) ? MAXP : pl)});
      if (ok) exp_good++;
      else    exp_bad++;
    end
  endtask

  task automatic make_frame(input bit pay[$], input int flip,
                            output bit q[$]);
    logic [15:0] c;
    c = crc_of(pay);
    q = pay;
    for (int i = 15; i >= 0; i--) q.push_back(c[i]);
    if (flip >= 0) q[flip] = !q[flip];
  endtask

  task automatic rand_bits(input int n, output bit q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(1'($urandom));
  endtask

  task automatic verify(input string tag);
    int n;
    int bad;
    idle(24);
    chk({tag, "_ndone"}, obs_done.size(), exp_done.size());
    n = (obs_done.size() < exp_done.size()) ?
        obs_done.size() : exp_done.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_done_cyc"}, obs_done[i].c, exp_done[i].c);
      chk({tag, "_ok"}, obs_done[i].ok, exp_done[i].ok);
      chk({tag, "_err"}, obs_done[i].err, exp_done[i].err);
      chk({tag, "_len"}, obs_done[i].len, exp_done[i].len);
    end
    if (exp_done.size() > 0)
      last_len = exp_done[exp_done.size()-1].len;
    chk({tag, "_npay"}, obs_pay.size(), exp_pay.size());
    n = (obs_pay.size() < exp_pay.size()) ?
        obs_pay.size() : exp_pay.size();
    bad = 0;
    for (int i = 0; i < n; i++)
      if (obs_pay[i] != exp_pay[i]) bad++;
    chk({tag, "_pay_bits"}, bad, 0);
    chk({tag, "_stray_ok_err"}, stray, 0);
    chk({tag, "_len_held"}, frame_len, last_len);
    obs_done = {};
    exp_done = {};
    obs_pay  = {};
    exp_pay  = {};
    stray    = 0;
  endtask

  initial begin
    bit       pay[$];
    bit       fr[$];
    bit       fr2[$];
    bit [7:0] a5;
    int       len;
    int       flip;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_payload_bit", payload_bit, 0);
    chk("rst_payload_valid", payload_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_crc_ok", crc_ok, 0);
    chk("rst_crc_err", crc_err, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_good", good_count, 0);
    chk("rst_bad", bad_count, 0);
    reset = 1'b0;
    idle(3);
    obs_done = {};
    obs_pay  = {};

    a5 = 8'hA5;
    pay = {};
    for (int i = 7; i >= 0; i--) pay.push_back(a5[i]);
    make_frame(pay, -1, fr);
    send_raw(fr, 1'b1, 0);
    verify("a5_good");

    make_frame(pay, 8 + 12, fr);
    send_raw(fr, 1'b1, 0);
    verify("a5_flip_tr3");

    rand_bits(10, fr);
    send_raw(fr, 1'b1, 0);
    verify("short10");

    rand_bits(16, pay);
    make_frame(pay, -1, fr);
    rand_bits(16, pay);
    make_frame(pay, -1, fr2);
    send_raw(fr, 1'b1, 0);
    send_raw(fr2, 1'b1, 0);
    verify("b2b32");

    rand_bits(10, fr);
    send_raw(fr, 1'b0, 0);
    rand_bits(8, pay);
    make_frame(pay, -1, fr);
    send_raw(fr, 1'b1, 0);
    verify("restart");

    rand_bits(20, fr);
    send_raw(fr, 1'b0, 0);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("mrst_payload_bit", payload_bit, 0);
    chk("mrst_payload_valid", payload_valid, 0);
    chk("mrst_done", done, 0);
    chk("mrst_crc_ok", crc_ok, 0);
    chk("mrst_crc_err", crc_err, 0);
    chk("mrst_frame_len", frame_len, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_good", good_count, 0);
    chk("mrst_bad", bad_count, 0);
    reset = 1'b0;
    exp_good = 0;
    exp_bad  = 0;
    last_len = 0;
    verify("midreset");

    rand_bits(1, fr);
    send_raw(fr, 1'b1, 0);
    rand_bits(16, fr);
    send_raw(fr, 1'b1, 0);
    rand_bits(1, pay);
    make_frame(pay, -1, fr);
    send_raw(fr, 1'b1, 0);
    verify("edge_lengths");

    rand_bits(MAXP, pay);
    make_frame(pay, -1, fr);
    send_raw(fr, 1'b1, 0);
    verify("max_len");

    rand_bits(MAXP + 1, pay);
    make_frame(pay, -1, fr);
    send_raw(fr, 1'b1, 0);
    verify("overflow");

    for (int k = 0; k < 40; k++) begin
      len  = $urandom_range(1, 48);
      flip = ($urandom_range(2) == 0) ?
             int'($urandom_range(0, len + 15)) : -1;
      rand_bits(len, pay);
      make_frame(pay, flip, fr);
      send_raw(fr, 1'b1, ($urandom_range(1) == 1) ? 25 : 0);
      if ($urandom_range(1) == 1) idle($urandom_range(1, 3));
    end
    verify("random");

`ifdef CRC_STATS_EN
    chk("good_count", good_count, exp_good);
    chk("bad_count", bad_count, exp_bad);
`else
    chk("good_count", good_count, 0);
    chk("bad_count", bad_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/crc16_frame_checker.md
# crc16_frame_checker

Receive-side companion to the bit-serial CRC-16 generator. It consumes a framed serial bit stream, runs the same LFSR over every bit, and reports at frame end whether the 16-bit CRC trailer was correct. The LFSR uses polynomial x^16+x^15+x^2+1, init 16'hFFFF, no final XOR, and the trailer is sent MSB first. It also forwards the payload bits with the trailer stripped, and reports payload length. It sits between the serial receive front end and the packet consumer.

## Interface
- LEN_W, 12, width of the payload bit counter; maximum payload is 2^LEN_W-1 bits.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is accepted this cycle; all other inputs are ignored when it is low.
- frame_start  in  1  qualified by bit_valid; marks the first bit of a frame.
- frame_end  in  1  qualified by bit_valid; marks the last bit, which is the LSB of the trailer.
- payload_bit  out  1  forwarded payload bit, registered.
- payload_valid  out  1  payload_bit is valid; single-cycle strobe per bit.
- done  out  1  one-cycle pulse when a frame's result is ready.
- crc_ok  out  1  valid with done: residue is 0 and length is legal.
- crc_err  out  1  valid with done: the inverse of crc_ok.
- frame_len  out  LEN_W  payload bits of the last frame (total bits − 16); held until the next done.
- busy  out  1  high while in the RUN state.
- good_count, bad_count  out  16  frame statistics (only with CRC_STATS_EN).

## Operation
- States: IDLE, RUN, REPORT. Reset puts the block in IDLE.
- Reset values: every output is 0. The LFSR is 16'hFFFF, the delay line is 0, and the counters are 0.
- LFSR update on each accepted bit d, where r is the LFSR:
  - r[0] ← r[15]^d
  - r[1] ← r[0]
  - r[2] ← r[1]^r[15]^d
  - r[14:3] ← r[13:2]
  - r[15] ← r[14]^r[15]^d
- IDLE, when bit_valid & frame_start:
  - Load the LFSR as if updated from 16'hFFFF with bit_in.
  - Set the total-bit count to 1.
  - Shift bit_in into the 16-bit delay line.
  - Go to RUN; if frame_end is also high, go to REPORT instead.
- IDLE, bits without frame_start are discarded.
- RUN, each accepted bit:
  - Update the LFSR.
  - Increment the count, saturating at 2^LEN_W+15 and setting a sticky overflow flag.
  - Shift the delay line.
  - If the count before this bit is ≥16, emit the bit shifted out of the delay line as payload.
- RUN, bit_valid low: hold all state.
- RUN, frame_start: abort the current frame with no done, then restart as in IDLE using the current bit.
- Frame_end bit: go to REPORT.
- REPORT (exactly one cycle):
  - Pulse done.
  - crc_ok = (residue == 0) & (count ≥ 17) & !overflow.
  - frame_len = count−16, or 0 if count < 16.
- REPORT with an accepted frame_start bit: start the new frame in the same cycle (back-to-back frames) and go to RUN. Otherwise go to IDLE.
- Trailer bits are never emitted on payload_valid.
- Reset mid-frame: the frame is dropped, with no done and no further payload output.

## Timing
- Payload latency: the bit accepted at cycle N appears on payload_bit/payload_valid at cycle N+17 of accepted bits, i.e. the cycle after the 16th following accepted bit.
- payload_valid is the registered result of the acceptance cycle, so it appears one clock after that cycle.
- done, crc_ok, crc_err and frame_len are registered and appear one clock after the frame_end bit is accepted.
- The last payload_valid pulse precedes done, or occurs in the same cycle as done.
- crc_ok and crc_err are 0 outside the done cycle.
- frame_len holds its value until the next done.
- Throughput: one bit per clock, with frames back to back with no gap.

## Configuration
- CRC_STATS_EN defined:
  - good_count increments on each done with crc_ok; bad_count increments on each done with crc_err.
  - Both saturate at 16'hFFFF and are cleared by reset.
- CRC_STATS_EN undefined: good_count and bad_count are tied to 0 and no counter logic is generated.

## Test plan
- Payload 8'hA5 followed by the correct CRC from the bench golden model: done at end+1, crc_ok=1, frame_len=8, and payload_valid pulses carry 1,0,1,0,0,1,0,1 in order.
- Same frame with trailer bit 3 flipped: crc_err=1, crc_ok=0, frame_len=8, and the payload bits are still forwarded.
- 10-bit frame (frame_start and frame_end 9 bits apart): crc_err=1, frame_len=0, and no payload_valid pulses.
- Two correct 32-bit frames back to back, with the second frame_start in the REPORT cycle and bit_valid held high throughout: two done pulses 32 cycles apart, both crc_ok, and 16+16 payload strobes.
- frame_start reasserted mid-frame, then a correct 24-bit frame: exactly one done with crc_ok=1 and frame_len=8. Separately, reset asserted mid-frame: no done, and all outputs are 0 on the next cycle.
- With CRC_STATS_EN: 3 good frames and 2 bad frames give good_count=3 and bad_count=2. Without it, both read 0.
